// File: rtl/psum_collector.sv
// psum_collector: deskews per-column partial sums from the systolic array into
// aligned rows, buffers them in a FIFO and streams them out over valid/ready.
module psum_collector #(
  parameter int unsigned N          = 4,
  parameter int unsigned C_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [C_WIDTH-1:0]     psum [N],
  input  logic [N-1:0]           valid_in,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   tile_rows,
  output logic [N*C_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   done,
  output logic                   busy,
  output logic                   overflow,
  output logic                   skew_err
);

  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CTW = AW + 1;
  localparam int unsigned RW  = N * C_WIDTH;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] target;
  logic [CNT_WIDTH-1:0] rows_in;
  logic [CNT_WIDTH-1:0] rows_out;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CTW-1:0]       count;
  logic [RW-1:0]        mem [FIFO_DEPTH];

  logic [C_WIDTH-1:0]   al_data [N];
  logic [N-1:0]         al_valid;
  logic [RW-1:0]        row_data;

  logic                 row_ok;
  logic                 skew_mis;
  logic                 rd;
  logic                 accept;
  logic                 full;
  logic                 wr;
  logic                 load;
  logic [CTW-1:0]       count_nxt;
  logic [CNT_WIDTH-1:0] rows_out_nxt;
  logic [CNT_WIDTH-1:0] target_nxt;

  // Deskew: column c is delayed by N-1-c registers so all lanes of a row line up
  for (genvar c = 0; c < N; c++) begin : g_col
    localparam int unsigned L = N - 1 - c;
    if (L == 0) begin : g_pass
      assign al_data[c]  = psum[c];
      assign al_valid[c] = valid_in[c];
    end else begin : g_dly
      logic [C_WIDTH-1:0] d_sh [L];
      logic [L-1:0]       v_sh;
      // Shift data and valid of this column through its delay line
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < int'(L); k++) d_sh[k] <= '0;
          v_sh <= '0;
        end else begin
          d_sh[0] <= psum[c];
          v_sh[0] <= valid_in[c];
          for (int k = 1; k < int'(L); k++) begin
            d_sh[k] <= d_sh[k-1];
            v_sh[k] <= v_sh[k-1];
          end
        end
      end
      assign al_data[c]  = d_sh[L-1];
      assign al_valid[c] = v_sh[L-1];
    end
  end

  // Pack aligned lanes into one row and derive handshake / FIFO controls
  always_comb begin
    row_data = '0;
    for (int c = 0; c < int'(N); c++) row_data[c*C_WIDTH +: C_WIDTH] = al_data[c];
    row_ok       = al_valid[0];
    skew_mis     = (|al_valid) && !(&al_valid);
    rd           = out_valid && out_ready;
    accept       = row_ok && (state == COLLECT);
    full         = (count == CTW'(FIFO_DEPTH));
    wr           = accept && (!full || rd);
    count_nxt    = count + CTW'(wr) - CTW'(rd);
    load         = (state == IDLE) && start && (tile_rows != '0);
    target_nxt   = load ? tile_rows : target;
    rows_out_nxt = load ? '0 : (rows_out + CNT_WIDTH'(rd));
  end

  // FIFO storage; contents need no reset because out_data is gated by out_valid
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= row_data;
  end

  // Tile FSM, FIFO pointers, row counters and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      target    <= '0;
      rows_in   <= '0;
      rows_out  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      skew_err  <= 1'b0;
    end else begin
      done     <= 1'b0;
      count    <= count_nxt;
      rows_out <= rows_out_nxt;
      target   <= target_nxt;
      if (wr) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (rd) rd_ptr <= AW'(rd_ptr + 1'b1);
      if (skew_mis) skew_err <= 1'b1;
      out_valid <= (count_nxt != '0);
      out_last  <= (count_nxt != '0) && (rows_out_nxt == CNT_WIDTH'(target_nxt - 1'b1));
      case (state)
        IDLE: begin
          if (load) begin
            rows_in <= '0;
            busy    <= 1'b1;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            rows_in <= CNT_WIDTH'(rows_in + 1'b1);
            if (full && !rd) overflow <= 1'b1;
            if (CNT_WIDTH'(rows_in + 1'b1) == target) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (row_ok) skew_err <= 1'b1;
          if (count_nxt == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Present the head row only while it is valid so an empty FIFO reads as zero
  assign out_data = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector: directed skewed rows in, expected rows
// queued by the stimulus, popped and compared by an independent monitor.
module tb_psum_collector;
  localparam int unsigned N    = 4;
  localparam int unsigned CW   = 32;
  localparam int unsigned DEP  = 8;
  localparam int unsigned CNTW = 16;
  localparam int unsigned RW   = N * CW;

  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   psum [N];
  logic [N-1:0]    valid_in;
  logic            start;
  logic [CNTW-1:0] tile_rows;
  logic [RW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            done;
  logic            busy;
  logic            overflow;
  logic            skew_err;

  psum_collector #(.N(N), .C_WIDTH(CW), .FIFO_DEPTH(DEP), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst(rst), .psum(psum), .valid_in(valid_in), .start(start),
    .tile_rows(tile_rows), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .done(done), .busy(busy),
    .overflow(overflow), .skew_err(skew_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   beats    = 0;
  int   first_beat_cyc = -1;
  int   last_beat_cyc  = -1;
  int   done_cnt = 0;
  int   done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  function automatic logic [CW-1:0] lane_val(input int base, input int r, input int c);
    return CW'(base + 16 * r + c);
  endfunction

  function automatic logic [RW-1:0] row_val(input int base, input int r, input int zero_lane);
    logic [RW-1:0] v;
    v = '0;
    for (int c = 0; c < int'(N); c++)
      if (c != zero_lane) v[c*CW +: CW] = lane_val(base, r, c);
    return v;
  endfunction

  task automatic push_rows(input int base, input int n, input logic last_on_final);
    exp_t e;
    for (int r = 0; r < n; r++) begin
      e.data = row_val(base, r, -1);
      e.last = last_on_final && (r == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pop and compare each handshake, record beat and done timing
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        exp_t e;
        if (beats == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        beats++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got data %0h with nothing expected", out_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", out_data, e.data);
          check("beat_last", RW'(out_last), RW'(e.last));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_mon();
    exp_q.delete();
    beats = 0; first_beat_cyc = -1; last_beat_cyc = -1; done_cnt = 0; done_cyc = -1;
  endtask

  task automatic reset_dut();
    @(posedge clk); #2 rst = 1'b0;
    clear_mon();
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic do_start(input int rows);
    @(posedge clk); #1 start = 1'b1; tile_rows = CNTW'(rows);
    @(posedge clk); #1 start = 1'b0; tile_rows = '0;
  endtask

  // Drive n skewed rows: lane c of row r appears at cycle t0+r+c (+1 for late_col)
  task automatic send_rows(input int n, input int base, input int late_col, input int ready_at,
                           output int t0);
    t0 = -1;
    for (int k = 0; k < n + int'(N); k++) begin
      @(posedge clk); #1;
      if (k == 0) t0 = cyc;
      valid_in = '0;
      for (int c = 0; c < int'(N); c++) begin
        int d;
        d = k - c - ((c == late_col) ? 1 : 0);
        psum[c] = '0;
        if (d >= 0 && d < n) begin
          valid_in[c] = 1'b1;
          psum[c] = lane_val(base, d, c);
        end
      end
      if (k == ready_at) out_ready = 1'b1;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (done_cnt == 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    @(negedge clk);
    check(name, RW'(done_cnt), RW'(1));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    exp_t e;
    rst = 1'b0; start = 1'b0; tile_rows = '0; valid_in = '0; out_ready = 1'b0;
    for (int c = 0; c < int'(N); c++) psum[c] = '0;

    // Reset state
    #1;
    check("rst_out_valid", RW'(out_valid), '0);
    check("rst_busy", RW'(busy), '0);
    check("rst_done", RW'(done), '0);
    check("rst_flags", RW'({overflow, skew_err, out_last}), '0);
    check("rst_out_data", out_data, '0);
    #20 rst = 1'b1;

    // 1: reset mid-tile clears everything immediately
    do_start(3);
    send_rows(2, 'h300, -1, -1, t0);
    wait_cycles(1);
    check("t1_pre_valid", RW'(out_valid), RW'(1));
    check("t1_pre_busy", RW'(busy), RW'(1));
    #2 rst = 1'b0;
    #1;
    check("t1_async_valid", RW'(out_valid), '0);
    check("t1_async_busy", RW'(busy), '0);
    check("t1_async_data", out_data, '0);
    check("t1_async_flags", RW'({overflow, skew_err, out_last, done}), '0);
    @(posedge clk); #1 rst = 1'b1;
    out_ready = 1'b1;
    wait_cycles(4);
    check("t1_fifo_empty", RW'(out_valid), '0);
    check("t1_no_beats", RW'(beats), '0);

    // 2: skewed stream, four aligned rows, last on beat 4, done one cycle later
    reset_dut();
    out_ready = 1'b1;
    do_start(4);
    push_rows(0, 4, 1'b1);
    send_rows(4, 0, -1, -1, t0);
    wait_done("t2_done");
    check("t2_first_beat_cyc", RW'(first_beat_cyc), RW'(t0 + 4));
    check("t2_last_beat_cyc", RW'(last_beat_cyc), RW'(t0 + 7));
    check("t2_done_cyc", RW'(done_cyc), RW'(t0 + 8));
    check("t2_beats", RW'(beats), RW'(4));
    check("t2_row2_const", row_val(0, 2, -1), RW'(128'h00000023_00000022_00000021_00000020));
    check("t2_flags", RW'({overflow, skew_err, busy}), '0);

    // 3: backpressure, 10 rows into 8 entries
    reset_dut();
    out_ready = 1'b0;
    do_start(10);
    push_rows('h1000, 8, 1'b0);
    send_rows(10, 'h1000, -1, -1, t0);
    wait_cycles(2);
    check("t3_overflow", RW'(overflow), RW'(1));
    check("t3_busy", RW'(busy), RW'(1));
    check("t3_no_beats_yet", RW'(beats), '0);
    out_ready = 1'b1;
    wait_done("t3_done");
    check("t3_beats", RW'(beats), RW'(8));
    check("t3_skew", RW'(skew_err), '0);
    check("t3_queue_empty", RW'(exp_q.size()), '0);

    // 4: full FIFO read and written on the same edge, no drop
    reset_dut();
    out_ready = 1'b0;
    do_start(9);
    push_rows('h2000, 8, 1'b0);
    e.data = row_val('h3000, 0, -1); e.last = 1'b1;
    exp_q.push_back(e);
    send_rows(8, 'h2000, -1, -1, t0);
    send_rows(1, 'h3000, -1, 3, t0);
    wait_done("t4_done");
    check("t4_overflow", RW'(overflow), '0);
    check("t4_beats", RW'(beats), RW'(9));
    check("t4_queue_empty", RW'(exp_q.size()), '0);

    // 5: column 2 one cycle late; row taken on column 0 timing with stale lane 2
    reset_dut();
    out_ready = 1'b1;
    do_start(1);
    e.data = row_val('h4000, 0, 2); e.last = 1'b1;
    exp_q.push_back(e);
    send_rows(1, 'h4000, 2, -1, t0);
    wait_done("t5_done");
    check("t5_skew_err", RW'(skew_err), RW'(1));
    check("t5_beats", RW'(beats), RW'(1));
    check("t5_overflow", RW'(overflow), '0);

    // 6: start rules and rows arriving in IDLE
    reset_dut();
    out_ready = 1'b1;
    do_start(0);
    wait_cycles(2);
    check("t6_zero_rows_busy", RW'(busy), '0);
    send_rows(2, 'h5000, -1, -1, t0);
    wait_cycles(3);
    check("t6_idle_no_beats", RW'(beats), '0);
    check("t6_idle_no_skew", RW'(skew_err), '0);
    do_start(2);
    do_start(5);
    check("t6_busy", RW'(busy), RW'(1));
    push_rows('h6000, 2, 1'b1);
    send_rows(2, 'h6000, -1, -1, t0);
    wait_done("t6_done");
    check("t6_beats", RW'(beats), RW'(2));
    check("t6_idle_after", RW'(busy), '0);
    wait_cycles(10);
    check("t6_single_done", RW'(done_cnt), RW'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
